// File: rtl/dht_pkg.sv
// Shared definitions for the DHT single-wire sensor reader: FSM state encoding,
// error codes, protocol timing constants and the received frame layout.
package dht_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE      = 4'd0;
   localparam state_t ST_START_LOW = 4'd1;
   localparam state_t ST_RELEASE   = 4'd2;
   localparam state_t ST_ACK_WAIT  = 4'd3;
   localparam state_t ST_ACK_LOW   = 4'd4;
   localparam state_t ST_ACK_HIGH  = 4'd5;
   localparam state_t ST_BIT_LOW   = 4'd6;
   localparam state_t ST_BIT_HIGH  = 4'd7;
   localparam state_t ST_CHECK     = 4'd8;
   localparam state_t ST_COOLDOWN  = 4'd9;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_NO_RESP = 3'd1;
   localparam logic [2:0] ERR_ACK_TO  = 3'd2;
   localparam logic [2:0] ERR_BIT_TO  = 3'd3;
   localparam logic [2:0] ERR_CSUM    = 3'd4;

   localparam int unsigned RELEASE_US = 30;
   localparam int unsigned BIT_ONE_US = 50;
   localparam int unsigned TIMEOUT_US = 100;
   localparam int unsigned FRAME_BITS = 40;

   typedef struct packed {
      logic [7:0] hum_int;
      logic [7:0] hum_frac;
      logic [7:0] temp_int;
      logic [7:0] temp_frac;
      logic [7:0] checksum;
   } frame_t;

   // 8-bit truncated sum of the four data bytes
   function automatic logic [7:0] frame_sum(input frame_t f);
      return f.hum_int + f.hum_frac + f.temp_int + f.temp_frac;
   endfunction

endpackage

// File: rtl/dht_us_tick.sv
// One-cycle microsecond strobe derived from the system clock frequency.
module dht_us_tick #(
   parameter int unsigned CLK_HZ = 50_000_000
)(
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int unsigned DIV = (CLK_HZ / 1_000_000 > 1) ? CLK_HZ / 1_000_000 : 1;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == CW'(DIV - 1)) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/dht_sensor_reader.sv
// Multi-channel DHT11/DHT22 single-wire reader with open-drain lines.
// Build option: define DHT_CHECKSUM_EN to reject frames with a bad checksum.
module dht_sensor_reader
   import dht_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 50_000_000,
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned COOLDOWN_MS  = 1000,
   parameter int unsigned START_LOW_MS = 18,
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [CH_W-1:0]   ch_sel,
   inout  wire  [NUM_CH-1:0] sensor_io,
   output logic              busy,
   output logic              done,
   output logic [2:0]        err_code,
   output logic [CH_W-1:0]   ch_out,
   output logic [7:0]        hum_int,
   output logic [7:0]        hum_frac,
   output logic [7:0]        temp_int,
   output logic [7:0]        temp_frac,
   output logic [7:0]        checksum
);

   localparam int unsigned START_US   = START_LOW_MS * 1000;
   localparam int unsigned CD_US      = COOLDOWN_MS * 1000;
   localparam int unsigned MAX_A      = (START_US > CD_US) ? START_US : CD_US;
   localparam int unsigned MAX_US     = (MAX_A > TIMEOUT_US) ? MAX_A : TIMEOUT_US;
   localparam int unsigned CNT_W      = $clog2(MAX_US + 1);
   localparam int unsigned START_LAST = (START_US > 0) ? START_US - 1 : 0;
   localparam int unsigned CD_LAST    = (CD_US > 0) ? CD_US - 1 : 0;

   logic              tick;
   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [5:0]        bit_idx, bit_idx_nxt;
   logic [39:0]       shreg, shreg_nxt;
   frame_t            data_q, data_nxt;
   logic [CH_W-1:0]   ch_lat, ch_lat_nxt;
   logic [CH_W-1:0]   ch_out_nxt;
   logic [NUM_CH-1:0] drive_low, drive_nxt;
   logic              busy_nxt, done_nxt;
   logic [2:0]        err_nxt;
   logic              sync1, sync2;
   logic              line_c;
   logic [NUM_CH-1:0] sel_mask_c, lat_mask_c;
   logic              fail_c, expired_c, bit_val_c, csum_ok_c;
   logic [2:0]        fail_code_c;

   dht_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
      .clock (clock),
      .reset (reset),
      .tick  (tick)
   );

   // Open-drain: only ever pull low, otherwise release
   for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_io
      assign sensor_io[g] = drive_low[g] ? 1'b0 : 1'bz;
   end

   // Channel decode and line select
   always_comb begin
      sel_mask_c = '0;
      lat_mask_c = '0;
      line_c     = 1'b1;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (CH_W'(i) == ch_sel) sel_mask_c[i] = 1'b1;
         if (CH_W'(i) == ch_lat) begin
            lat_mask_c[i] = 1'b1;
            line_c        = sensor_io[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= line_c;
         sync2 <= sync1;
      end
   end

   always_comb begin
`ifdef DHT_CHECKSUM_EN
      csum_ok_c = (frame_sum(frame_t'(shreg)) == shreg[7:0]);
`else
      csum_ok_c = 1'b1;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         data_q    <= '0;
         ch_lat    <= '0;
         ch_out    <= '0;
         drive_low <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shreg     <= shreg_nxt;
         data_q    <= data_nxt;
         ch_lat    <= ch_lat_nxt;
         ch_out    <= ch_out_nxt;
         drive_low <= drive_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         err_code  <= err_nxt;
      end
   end

   // Next-state and registered-output logic; cnt counts microseconds in the current state
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = tick ? cnt + CNT_W'(1) : cnt;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      data_nxt    = data_q;
      ch_lat_nxt  = ch_lat;
      ch_out_nxt  = ch_out;
      drive_nxt   = '0;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      err_nxt     = err_code;
      fail_c      = 1'b0;
      fail_code_c = ERR_NONE;
      expired_c   = tick && (cnt == CNT_W'(TIMEOUT_US - 1));
      bit_val_c   = (cnt > CNT_W'(BIT_ONE_US));

      case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (start) begin
               ch_lat_nxt  = ch_sel;
               busy_nxt    = 1'b1;
               err_nxt     = ERR_NONE;
               bit_idx_nxt = '0;
               drive_nxt   = sel_mask_c;
               state_nxt   = ST_START_LOW;
            end
         end
         ST_START_LOW: begin
            drive_nxt = lat_mask_c;
            if (tick && cnt == CNT_W'(START_LAST)) begin
               drive_nxt = '0;
               cnt_nxt   = '0;
               state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (tick && cnt == CNT_W'(RELEASE_US - 1)) begin
               cnt_nxt   = '0;
               state_nxt = ST_ACK_WAIT;
            end
         end
         ST_ACK_WAIT: begin
            if (!sync2) begin
               cnt_nxt   = '0;
               state_nxt = ST_ACK_LOW;
            end else if (expired_c) begin
               fail_c      = 1'b1;
               fail_code_c = ERR_NO_RESP;
            end
         end
         ST_ACK_LOW: begin
            if (sync2) begin
               cnt_nxt   = '0;
               state_nxt = ST_ACK_HIGH;
            end else if (expired_c) begin
               fail_c      = 1'b1;
               fail_code_c = ERR_ACK_TO;
            end
         end
         ST_ACK_HIGH: begin
            if (!sync2) begin
               cnt_nxt     = '0;
               bit_idx_nxt = '0;
               state_nxt   = ST_BIT_LOW;
            end else if (expired_c) begin
               fail_c      = 1'b1;
               fail_code_c = ERR_ACK_TO;
            end
         end
         ST_BIT_LOW: begin
            if (sync2) begin
               cnt_nxt   = '0;
               state_nxt = ST_BIT_HIGH;
            end else if (expired_c) begin
               fail_c      = 1'b1;
               fail_code_c = ERR_BIT_TO;
            end
         end
         ST_BIT_HIGH: begin
            if (!sync2) begin
               cnt_nxt   = '0;
               shreg_nxt = {shreg[38:0], bit_val_c};
               if (bit_idx == 6'(FRAME_BITS - 1)) begin
                  state_nxt = ST_CHECK;
               end else begin
                  bit_idx_nxt = bit_idx + 6'd1;
                  state_nxt   = ST_BIT_LOW;
               end
            end else if (expired_c) begin
               fail_c      = 1'b1;
               fail_code_c = ERR_BIT_TO;
            end
         end
         ST_CHECK: begin
            cnt_nxt    = '0;
            done_nxt   = 1'b1;
            ch_out_nxt = ch_lat;
            state_nxt  = ST_COOLDOWN;
            if (csum_ok_c) begin
               data_nxt = frame_t'(shreg);
               err_nxt  = ERR_NONE;
            end else begin
               err_nxt  = ERR_CSUM;
            end
         end
         ST_COOLDOWN: begin
            if (tick && cnt == CNT_W'(CD_LAST)) begin
               cnt_nxt   = '0;
               busy_nxt  = 1'b0;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase

      // Any protocol error releases the line and reports through the cooldown path
      if (fail_c) begin
         cnt_nxt    = '0;
         done_nxt   = 1'b1;
         err_nxt    = fail_code_c;
         ch_out_nxt = ch_lat;
         drive_nxt  = '0;
         state_nxt  = ST_COOLDOWN;
      end
   end

   assign hum_int   = data_q.hum_int;
   assign hum_frac  = data_q.hum_frac;
   assign temp_int  = data_q.temp_int;
   assign temp_frac = data_q.temp_frac;
   assign checksum  = data_q.checksum;

endmodule

// File: tb/tb_dht_sensor_reader.sv
// Self-checking bench: table of sensor transactions with a done-driven scoreboard,
// plus hand-written sequences for reset, busy-time starts and cooldown timing.
`timescale 1ns/1ps
module tb_dht_sensor_reader;

   localparam int unsigned NCH = 4;
   localparam int M_NORMAL  = 0;
   localparam int M_SILENT  = 1;
   localparam int M_ACKTO   = 2;
   localparam int M_STRETCH = 3;
`ifdef DHT_CHECKSUM_EN
   localparam logic [2:0] CSUM_BAD_ERR = 3'd4;
`else
   localparam logic [2:0] CSUM_BAD_ERR = 3'd0;
`endif

   logic           clock = 1'b0;
   logic           reset;
   logic           start;
   logic [1:0]     ch_sel;
   wire  [NCH-1:0] sensor_io;
   logic           busy, done;
   logic [2:0]     err_code;
   logic [1:0]     ch_out;
   logic [7:0]     hum_int, hum_frac, temp_int, temp_frac, checksum;
   logic [NCH-1:0] sens_low;

   always #500 clock = ~clock;

   for (genvar g = 0; g < int'(NCH); g++) begin : g_line
      assign sensor_io[g] = sens_low[g] ? 1'b0 : 1'bz;
      pullup (sensor_io[g]);
   end

   dht_sensor_reader #(
      .CLK_HZ(1_000_000), .NUM_CH(NCH), .COOLDOWN_MS(2), .START_LOW_MS(1)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .ch_sel(ch_sel),
      .sensor_io(sensor_io), .busy(busy), .done(done), .err_code(err_code),
      .ch_out(ch_out), .hum_int(hum_int), .hum_frac(hum_frac),
      .temp_int(temp_int), .temp_frac(temp_frac), .checksum(checksum)
   );

   typedef struct {
      int          ch;
      logic [39:0] frame;
      int          mode;
      logic [2:0]  exp_err;
   } vec_t;

   typedef struct {
      logic [2:0]  err;
      logic [1:0]  ch;
      logic [39:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   done_cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest pending expectation
   always @(negedge clock) begin
      if (done) begin
         exp_t e;
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(done), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("err_code", 64'(err_code), 64'(e.err));
            check("ch_out", 64'(ch_out), 64'(e.ch));
            check("data", 64'({hum_int, hum_frac, temp_int, temp_frac, checksum}), 64'(e.data));
         end
      end
   end

   task automatic cyc_wait(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_line(input int ch, input logic val, input int limit, input string name);
      int n = 0;
      while (sensor_io[ch] !== val && n < limit) begin
         @(negedge clock);
         n++;
      end
      if (sensor_io[ch] !== val) check(name, 64'(sensor_io[ch]), 64'(val));
   endtask

   // Sensor side of the protocol; stop_after ends the frame early with the line released
   task automatic respond(input int ch, input logic [39:0] fr, input int mode, input int stop_after);
      logic [39:0] f;
      f = fr;
      if (mode == M_SILENT) return;
      cyc_wait(35);
      sens_low[ch] = 1'b1;
      if (mode == M_ACKTO) begin
         cyc_wait(150);
         sens_low[ch] = 1'b0;
         return;
      end
      cyc_wait(80);
      sens_low[ch] = 1'b0;
      cyc_wait(80);
      for (int i = 0; i < 40; i++) begin
         if (i == stop_after) return;
         sens_low[ch] = 1'b1;
         cyc_wait(50);
         sens_low[ch] = 1'b0;
         if (mode == M_STRETCH && i == 20) begin
            cyc_wait(150);
            return;
         end
         cyc_wait(f[39-i] ? 70 : 26);
      end
      sens_low[ch] = 1'b1;
      cyc_wait(50);
      sens_low[ch] = 1'b0;
   endtask

   vec_t        vecs[8];
   logic [39:0] model_data = '0;

   initial begin
      int prev, n, rel_cyc, dcyc;
      exp_t e;

      vecs[0] = '{2, 40'h37_00_19_05_55, M_NORMAL,  3'd0};
      vecs[1] = '{0, 40'h11_22_33_44_AA, M_SILENT,  3'd1};
      vecs[2] = '{2, 40'h37_00_19_05_56, M_NORMAL,  CSUM_BAD_ERR};
      vecs[3] = '{1, 40'h41_02_1A_08_65, M_STRETCH, 3'd3};
      vecs[4] = '{3, 40'hFF_FF_FF_FF_FC, M_NORMAL,  3'd0};
      vecs[5] = '{0, 40'h12_34_56_78_14, M_ACKTO,   3'd2};
      vecs[6] = '{1, 40'h12_34_56_78_14, M_NORMAL,  3'd0};
      vecs[7] = '{3, 40'h00_00_00_00_00, M_NORMAL,  3'd0};

      reset = 1'b1; start = 1'b0; ch_sel = '0; sens_low = '0;
      cyc_wait(3);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err_code), 64'(0));
      check("rst_ch_out", 64'(ch_out), 64'(0));
      check("rst_data", 64'({hum_int, hum_frac, temp_int, temp_frac, checksum}), 64'(0));
      check("rst_lines", 64'(sensor_io), 64'(4'hF));
      reset = 1'b0;
      cyc_wait(2);

      for (int v = 0; v < 8; v++) begin
         prev = done_cnt;
         ch_sel = 2'(vecs[v].ch);
         start = 1'b1;
         e.err = vecs[v].exp_err;
         e.ch  = 2'(vecs[v].ch);
         if (vecs[v].exp_err == 3'd0) model_data = vecs[v].frame;
         e.data = model_data;
         exp_q.push_back(e);
         @(negedge clock);
         start = 1'b0;
         check("busy_after_start", 64'(busy), 64'(1));
         wait_line(vecs[v].ch, 1'b0, 5, "start_low_seen");
         check("unselected_hiz", 64'(sensor_io | (4'b1 << vecs[v].ch)), 64'(4'hF));
         wait_line(vecs[v].ch, 1'b1, 1100, "release_seen");
         rel_cyc = cyc;
         respond(vecs[v].ch, vecs[v].frame, vecs[v].mode, 99);

         n = 0;
         while (done_cnt == prev && n < 3000) begin
            @(negedge clock);
            n++;
         end
         if (done_cnt == prev) check("done_timeout", 64'(0), 64'(1));
         if (vecs[v].mode == M_SILENT) begin
            check_range("no_resp_latency", done_cyc - rel_cyc, 125, 140);
            check("silent_line_hiz", 64'(sensor_io), 64'(4'hF));
         end
         if (vecs[v].mode == M_STRETCH) begin
            for (int k = 0; k < 3; k++) begin
               ch_sel = 2'd0;
               start = 1'b1;
               @(negedge clock);
               start = 1'b0;
               cyc_wait(5);
            end
            check("busy_ignored_start", 64'(busy), 64'(1));
            check("err_held", 64'(err_code), 64'(3));
            check("ch_held", 64'(ch_out), 64'(1));
         end

         n = 0;
         while (busy && n < 2500) begin
            @(negedge clock);
            n++;
         end
         dcyc = cyc - done_cyc;
         check("cooldown_len", 64'(dcyc), 64'(2000));
         check("idle_lines", 64'(sensor_io), 64'(4'hF));
         cyc_wait(3);
      end

      // Reset in the middle of bit 10 aborts without done or cooldown
      ch_sel = 2'd1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_line(1, 1'b0, 5, "rst_seq_start");
      wait_line(1, 1'b1, 1100, "rst_seq_release");
      respond(1, 40'hAA_55_AA_55_54, M_NORMAL, 10);
      sens_low[1] = 1'b1;
      cyc_wait(20);
      reset = 1'b1;
      sens_low = '0;
      @(negedge clock);
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_lines", 64'(sensor_io), 64'(4'hF));
      check("abort_data", 64'({hum_int, hum_frac, temp_int, temp_frac, checksum}), 64'(0));
      reset = 1'b0;
      cyc_wait(2500);
      check("abort_idle_busy", 64'(busy), 64'(0));
      check("pending_expect", 64'(exp_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
